// File: rtl/display_link_pkg.sv
// Shared constants for the display link framer: clock-lane codes, sideband bit layout, CRC.
package display_link_pkg;

  localparam logic [11:0] CODE_IDLE         = 12'h00F;
  localparam logic [11:0] CODE_PIX          = 12'h01F;
  localparam logic [11:0] CODE_PIX_FIRST    = 12'h03F;
  localparam logic [11:0] CODE_SB           = 12'h07F;
  localparam logic [11:0] CODE_SB_PIX       = 12'h0FF;
  localparam logic [11:0] CODE_SB_PIX_FIRST = 12'h1FF;
  localparam logic [11:0] CODE_SYNC         = 12'hFFF;

  // Sideband layout: offsets above the PIO data field are relative to PIO_W.
  localparam int SB_VLD_BIT  = 0;
  localparam int SB_DAT_LSB  = 1;
  localparam int SB_SCL_OFS  = 1;
  localparam int SB_SDA_OFS  = 2;
  localparam int SB_CRC_OFS  = 3;
  localparam int CRC_W       = 8;

  localparam logic [7:0] CRC_POLY = 8'h07;

  function automatic logic [11:0] clk_code(input logic b, input logic acc, input logic first);
    logic [11:0] code;
    if (!b && !acc)      code = CODE_IDLE;
    else if (!b)         code = first ? CODE_PIX_FIRST : CODE_PIX;
    else if (!acc)       code = CODE_SB;
    else                 code = first ? CODE_SB_PIX_FIRST : CODE_SB_PIX;
    return code;
  endfunction

  // Non-reflected CRC-8, MSB of each byte shifted in first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] dat);
    logic [7:0] r;
    r = crc ^ dat;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/display_link_pio_fifo.sv
// Synchronous PIO word FIFO with occupancy level; push ignored when full, pop ignored when empty.
module display_link_pio_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             c,
  input  logic             r_n,
  input  logic             i_push_vld,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [W-1:0]     o_head_dat,
  output logic [LVL_W-1:0] o_level
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_level == LVL_W'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign w_push     = i_push_vld && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rp];
  assign o_level    = r_level;

  always_ff @(posedge c) begin
    if (w_push) r_mem[r_wp] <= i_push_dat;
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

endmodule

// File: rtl/display_link_framer.sv
// Display link TDM transmit framer: 4*SLOTS-cycle frame, outputs registered one cycle after cnt.
// Optional CRC-8 of the previous frame's pixels in the sideband word when DISPLAY_LINK_CRC_EN is defined.
module display_link_framer
  import display_link_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int SLOTS     = 25,
  parameter int PIX_SLOTS = 20,
  parameter int PIO_W     = 12,
  parameter int PIO_DEPTH = 4,
  localparam int PIXEL_W  = 16 * LANES,
  localparam int LVL_W    = $clog2(PIO_DEPTH + 1)
) (
  input  logic               c,
  input  logic               r_n,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               pixel_first,
  input  logic               sda_t,
  input  logic               scl_t,
  input  logic               pio_valid,
  output logic               pio_ready,
  input  logic [PIO_W-1:0]   pio_data,
  output logic [LVL_W-1:0]   pio_level,
  input  logic               invert_d,
  input  logic               invert_c,
  output logic [4*LANES-1:0] d_nib,
  output logic [3:0]         c_nib,
  output logic               frame_start
);

  localparam int CNT_W  = $clog2(4 * SLOTS);
  localparam int SLOT_W = CNT_W - 2;

  logic [CNT_W-1:0]   r_cnt;
  logic [SLOT_W-1:0]  w_slot;
  logic [1:0]         w_phase;
  logic               w_cnt_zero;
  logic               w_cnt_last;
  logic               w_accept;

  logic               w_full;
  logic               w_empty;
  logic [PIO_W-1:0]   w_head;
  logic               w_push;
  logic               w_pop;

  logic [SLOTS-1:0]   r_sb;
  logic [SLOTS-1:0]   w_sb_new;
  logic [SLOTS-1:0]   w_sb;
  logic [11:0]        w_code;
  logic [7:0]         r_code_hi;
  logic [3:0]         w_c_nxt;
  logic [3:0]         r_c;

  logic [PIXEL_W-1:0] r_sr;
  logic [PIXEL_W-1:0] w_cur;
  logic [PIXEL_W-1:0] w_sr_nxt;
  logic [4*LANES-1:0] w_d_nxt;
  logic [4*LANES-1:0] r_d;
  logic               r_fs;

  assign w_slot     = r_cnt[CNT_W-1:2];
  assign w_phase    = r_cnt[1:0];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == CNT_W'(4 * SLOTS - 1));

  assign pixel_ready = (w_phase == 2'd0) && (w_slot < SLOT_W'(PIX_SLOTS)) && r_n;
  assign w_accept    = pixel_valid && pixel_ready;

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n)            r_cnt <= '0;
    else if (w_cnt_last) r_cnt <= '0;
    else                 r_cnt <= r_cnt + 1'b1;
  end

  assign pio_ready = !w_full && r_n;
  assign w_push    = pio_valid && pio_ready;
  assign w_pop     = w_cnt_zero && !w_empty;

  display_link_pio_fifo #(
    .W     (PIO_W),
    .DEPTH (PIO_DEPTH)
  ) u_pio_fifo (
    .c          (c),
    .r_n        (r_n),
    .i_push_vld (w_push),
    .i_push_dat (pio_data),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head),
    .o_level    (pio_level)
  );

`ifdef DISPLAY_LINK_CRC_EN
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_crc_base;
  logic [CRC_W-1:0] w_crc_nxt;

  // The frame's CRC restarts at cnt 0, so a pixel accepted in slot 0 belongs to the new frame.
  always_comb begin
    w_crc_base = w_cnt_zero ? '0 : r_crc;
    w_crc_nxt  = w_crc_base;
    if (w_accept) begin
      for (int k = 0; k < PIXEL_W / 8; k++) begin
        w_crc_nxt = crc8_byte(w_crc_nxt, pixel_data[8*k +: 8]);
      end
    end
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) r_crc <= '0;
    else      r_crc <= w_crc_nxt;
  end
`endif

  always_comb begin
    w_sb_new                            = '0;
    w_sb_new[SB_VLD_BIT]                = !w_empty;
    w_sb_new[SB_DAT_LSB +: PIO_W]       = w_empty ? '0 : w_head;
    w_sb_new[PIO_W + SB_SCL_OFS]        = scl_t;
    w_sb_new[PIO_W + SB_SDA_OFS]        = sda_t;
`ifdef DISPLAY_LINK_CRC_EN
    w_sb_new[PIO_W + SB_CRC_OFS +: CRC_W] = r_crc;
`endif
  end

  // Slot 0 must see the word being latched this very cycle, not last frame's.
  assign w_sb   = w_cnt_zero ? w_sb_new : r_sb;
  assign w_code = (w_slot == SLOT_W'(SLOTS - 1)) ? CODE_SYNC
                                                 : clk_code(w_sb[w_slot], w_accept, pixel_first);

  always_comb begin
    case (w_phase)
      2'd0:    w_c_nxt = w_code[3:0];
      2'd1:    w_c_nxt = r_code_hi[3:0];
      2'd2:    w_c_nxt = r_code_hi[7:4];
      default: w_c_nxt = 4'h0;
    endcase
  end

  always_comb begin
    w_cur    = w_accept ? pixel_data : r_sr;
    w_sr_nxt = '0;
    w_d_nxt  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_d_nxt[4*l +: 4]    = w_cur[16*l +: 4];
      w_sr_nxt[16*l +: 16] = {4'h0, w_cur[16*l+4 +: 12]};
    end
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      r_sr      <= '0;
      r_d       <= '0;
      r_c       <= '0;
      r_code_hi <= '0;
      r_sb      <= '0;
      r_fs      <= 1'b0;
    end else begin
      r_sr <= w_sr_nxt;
      r_d  <= w_d_nxt;
      r_c  <= w_c_nxt;
      r_fs <= w_cnt_zero;
      if (w_phase == 2'd0) r_code_hi <= w_code[11:4];
      if (w_cnt_zero)      r_sb      <= w_sb_new;
    end
  end

  assign d_nib       = r_d ^ {4*LANES{invert_d}};
  assign c_nib       = r_c ^ {4{invert_c}};
  assign frame_start = r_fs;

endmodule

// File: tb/tb_display_link_framer.sv
// Directed bench for display_link_framer: per-cycle nibble tables per frame, FIFO, reset and CRC cases.
module tb_display_link_framer;

  logic        c = 1'b0;
  logic        r_n = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [15:0] pixel_data = '0;
  logic        pixel_first = 1'b0;
  logic        sda_t = 1'b0;
  logic        scl_t = 1'b0;
  logic        pio_valid = 1'b0;
  logic        pio_ready;
  logic [11:0] pio_data = '0;
  logic [2:0]  pio_level;
  logic        invert_d = 1'b0;
  logic        invert_c = 1'b0;
  logic [3:0]  d_nib;
  logic [3:0]  c_nib;
  logic        frame_start;

  always #4 c = ~c;

  display_link_framer dut (
    .c           (c),
    .r_n         (r_n),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_data  (pixel_data),
    .pixel_first (pixel_first),
    .sda_t       (sda_t),
    .scl_t       (scl_t),
    .pio_valid   (pio_valid),
    .pio_ready   (pio_ready),
    .pio_data    (pio_data),
    .pio_level   (pio_level),
    .invert_d    (invert_d),
    .invert_c    (invert_c),
    .d_nib       (d_nib),
    .c_nib       (c_nib),
    .frame_start (frame_start)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   tb_cnt = 0;
  int   frame_no = 0;
  bit   chk_en = 1'b0;
  logic [3:0] exp_c [100];
  logic [3:0] exp_d [100];
  logic [24:0] sb_tab [4];
  logic [2:0]  lvl_tab [4];
  logic [24:0] crc_sb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s frame %0d cnt %0d: got %0h expected %0h", tag, frame_no, tb_cnt, got, exp);
    end
  endtask

  task automatic set_code(input int s, input logic [11:0] code);
    exp_c[4*s]   = code[3:0];
    exp_c[4*s+1] = code[7:4];
    exp_c[4*s+2] = code[11:8];
    exp_c[4*s+3] = 4'h0;
  endtask

  task automatic init_frame(input logic [24:0] sb);
    for (int s = 0; s < 24; s++) set_code(s, sb[s] ? 12'h07F : 12'h00F);
    set_code(24, 12'hFFF);
    for (int i = 0; i < 100; i++) exp_d[i] = 4'h0;
  endtask

  task automatic set_pix(input int cnt0, input logic [15:0] p);
    for (int i = 0; i < 4; i++) exp_d[cnt0 + i] = p[4*i +: 4];
  endtask

  // One cycle: sample the outputs of the cnt just processed, then step the bench's cnt.
  task automatic tick();
    @(negedge c);
    if (chk_en) begin
      chk("c_nib", 32'(c_nib), 32'(exp_c[tb_cnt] ^ {4{invert_c}}));
      chk("d_nib", 32'(d_nib), 32'(exp_d[tb_cnt] ^ {4{invert_d}}));
      chk("frame_start", 32'(frame_start), 32'(tb_cnt == 0));
    end
    tb_cnt = (tb_cnt + 1) % 100;
    if (tb_cnt == 0) frame_no++;
    if (chk_en) chk("pixel_ready", 32'(pixel_ready), 32'((tb_cnt % 4 == 0) && (tb_cnt < 80)));
  endtask

`ifdef DISPLAY_LINK_CRC_EN
  function automatic logic [7:0] crc_pix(input logic [7:0] crc, input logic [15:0] p);
    logic [7:0] r;
    logic       fb;
    r = crc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = r[7] ^ p[8*k + i];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction
`endif

  initial begin
    repeat (3) @(negedge c);
    chk("rst_d_nib", 32'(d_nib), 32'h0);
    chk("rst_c_nib", 32'(c_nib), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_pixel_ready", 32'(pixel_ready), 32'h0);
    chk("rst_pio_ready", 32'(pio_ready), 32'h0);
    chk("rst_pio_level", 32'(pio_level), 32'h0);
    r_n = 1'b1;
    tb_cnt = 0;
    chk_en = 1'b1;

    // Frame 0: idle
    init_frame(25'h0);
    repeat (100) tick();
    chk("idle_pio_ready", 32'(pio_ready), 32'h1);

    // Frame 1: pixel held valid from cnt 0, second pixel at slot 1
    init_frame(25'h0);
    set_code(0, 12'h03F);
    set_code(1, 12'h01F);
    set_pix(0, 16'hA5C3);
    set_pix(4, 16'h1234);
    for (int i = 0; i < 100; i++) begin
      pixel_valid = (tb_cnt <= 4);
      pixel_data  = (tb_cnt < 4) ? 16'hA5C3 : 16'h1234;
      pixel_first = (tb_cnt < 4);
      tick();
    end
    pixel_valid = 1'b0;
    pixel_first = 1'b0;

    // Frame 2: single PIO push mid-frame
    crc_sb = 25'h0;
`ifdef DISPLAY_LINK_CRC_EN
    crc_sb = {2'b0, crc_pix(crc_pix(8'h00, 16'hA5C3), 16'h1234), 15'h0};
`endif
    init_frame(crc_sb);
    for (int i = 0; i < 100; i++) begin
      pio_valid = (tb_cnt == 50);
      pio_data  = 12'h5A3;
      if (tb_cnt == 50) chk("push1_ready", 32'(pio_ready), 32'h1);
      tick();
      if (tb_cnt == 51) chk("push1_level", 32'(pio_level), 32'h1);
    end
    pio_valid = 1'b0;

    // Frame 3: sb = 0xB47
    init_frame(25'hB47);
    for (int i = 0; i < 100; i++) begin
      if (tb_cnt == 0) chk("pop1_level_before", 32'(pio_level), 32'h1);
      tick();
      if (tb_cnt == 1) chk("pop1_level_after", 32'(pio_level), 32'h0);
    end

    // Frame 4: I2C bits latched at cnt 0 only, pixels in slots 13, 14, 19; slot 20 refuses
    init_frame(25'h6000);
    set_code(13, 12'h1FF);
    set_code(14, 12'h0FF);
    set_code(19, 12'h01F);
    set_pix(52, 16'h0F0F);
    set_pix(56, 16'h8421);
    set_pix(76, 16'h0001);
    for (int i = 0; i < 100; i++) begin
      scl_t       = (tb_cnt == 0);
      sda_t       = (tb_cnt == 0);
      pixel_valid = (tb_cnt == 52) || (tb_cnt == 56) || (tb_cnt == 76) || (tb_cnt == 80);
      pixel_first = (tb_cnt == 52) || (tb_cnt == 80);
      case (tb_cnt)
        52:      pixel_data = 16'h0F0F;
        56:      pixel_data = 16'h8421;
        76:      pixel_data = 16'h0001;
        default: pixel_data = 16'hFFFF;
      endcase
      tick();
    end
    pixel_valid = 1'b0;
    pixel_first = 1'b0;
    scl_t = 1'b0;
    sda_t = 1'b0;

    // Frame 5: both polarities inverted
    crc_sb = 25'h0;
`ifdef DISPLAY_LINK_CRC_EN
    crc_sb = {2'b0, crc_pix(crc_pix(crc_pix(8'h00, 16'h0F0F), 16'h8421), 16'h0001), 15'h0};
`endif
    init_frame(crc_sb);
    invert_d = 1'b1;
    invert_c = 1'b1;
    repeat (100) tick();
    invert_d = 1'b0;
    invert_c = 1'b0;

    // Frame 6: five words back-to-back from cnt 10
    init_frame(25'h0);
    for (int i = 0; i < 100; i++) begin
      pio_valid = (tb_cnt >= 10);
      case (tb_cnt)
        10:      pio_data = 12'h001;
        11:      pio_data = 12'h800;
        12:      pio_data = 12'hFFF;
        13:      pio_data = 12'h555;
        default: pio_data = 12'h0A0;
      endcase
      if (tb_cnt == 13) chk("fill_ready_4th", 32'(pio_ready), 32'h1);
      if (tb_cnt == 14) chk("full_ready", 32'(pio_ready), 32'h0);
      if (tb_cnt == 14) chk("full_level", 32'(pio_level), 32'h4);
      tick();
    end

    // Frame 7: head 0x001; pending 5th word enters right after the pop
    init_frame(25'h003);
    for (int i = 0; i < 100; i++) begin
      pio_valid = (tb_cnt <= 1);
      if (tb_cnt == 0) chk("full_pop_ready", 32'(pio_ready), 32'h0);
      tick();
      if (tb_cnt == 1) chk("after_pop_level", 32'(pio_level), 32'h3);
      if (tb_cnt == 1) chk("after_pop_ready", 32'(pio_ready), 32'h1);
      if (tb_cnt == 2) chk("refill_level", 32'(pio_level), 32'h4);
      if (tb_cnt == 2) chk("refill_ready", 32'(pio_ready), 32'h0);
    end
    pio_valid = 1'b0;

    // Frames 8-11: drain one word per frame
    sb_tab  = '{25'h1001, 25'h1FFF, 25'hAAB, 25'h141};
    lvl_tab = '{3'd3, 3'd2, 3'd1, 3'd0};
    for (int f = 0; f < 4; f++) begin
      init_frame(sb_tab[f]);
      for (int i = 0; i < 100; i++) begin
        tick();
        if (tb_cnt == 50) chk("drain_level", 32'(pio_level), 32'(lvl_tab[f]));
      end
    end

    // Frame 12: push while empty at cnt 0 -> kept for next frame
    init_frame(25'h0);
    for (int i = 0; i < 100; i++) begin
      pio_valid = (tb_cnt == 0);
      pio_data  = 12'h123;
      tick();
      if (tb_cnt == 1) chk("empty_push_level", 32'(pio_level), 32'h1);
    end
    pio_valid = 1'b0;

    // Frame 13: sb = 0x247
    init_frame(25'h247);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tb_cnt == 1) chk("empty_push_pop_level", 32'(pio_level), 32'h0);
    end

    // Frame 14: reset at cnt 57 with a pixel and a PIO word in flight
    init_frame(25'h0);
    set_code(14, 12'h01F);
    exp_d[56] = 4'hF;
    for (int i = 0; i < 57; i++) begin
      pio_valid   = (tb_cnt == 20);
      pio_data    = 12'h321;
      pixel_valid = (tb_cnt == 56);
      pixel_data  = 16'hBEEF;
      tick();
    end
    pio_valid   = 1'b0;
    pixel_valid = 1'b0;
    chk("pre_rst_level", 32'(pio_level), 32'h1);
    chk_en = 1'b0;
    r_n = 1'b0;
    #1;
    chk("mid_rst_d_nib", 32'(d_nib), 32'h0);
    chk("mid_rst_c_nib", 32'(c_nib), 32'h0);
    chk("mid_rst_frame_start", 32'(frame_start), 32'h0);
    chk("mid_rst_pio_level", 32'(pio_level), 32'h0);
    chk("mid_rst_pio_ready", 32'(pio_ready), 32'h0);
    chk("mid_rst_pixel_ready", 32'(pixel_ready), 32'h0);
    repeat (2) @(negedge c);
    chk("mid_rst_hold_c_nib", 32'(c_nib), 32'h0);
    r_n = 1'b1;
    tb_cnt = 0;
    frame_no++;
    chk_en = 1'b1;

    // Frame 15: restarts at cnt 0 with an empty FIFO
    init_frame(25'h0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tb_cnt == 1) chk("post_rst_level", 32'(pio_level), 32'h0);
    end

`ifdef DISPLAY_LINK_CRC_EN
    // Frame 16: one pixel 0x0001; frame 17 carries its CRC 0x15 in sb[22:15]
    init_frame(25'h0);
    set_code(0, 12'h03F);
    set_pix(0, 16'h0001);
    for (int i = 0; i < 100; i++) begin
      pixel_valid = (tb_cnt == 0);
      pixel_first = (tb_cnt == 0);
      pixel_data  = 16'h0001;
      tick();
    end
    pixel_valid = 1'b0;
    pixel_first = 1'b0;
    init_frame(25'hA8000);
    repeat (100) tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
